// File: rtl/anasymod_sched_pkg.sv
// Shared types for the emulator time-step scheduler: command modes, FSM states
// and the queued command record.
package anasymod_sched_pkg;

  // Width of the command payload carried through the queue; the top's
  // TIME_WIDTH parameter defaults to this and must be kept equal to it.
  localparam int SCHED_TIME_W = 40;

  typedef enum logic [1:0] {
    FREE    = 2'b00,
    STALL   = 2'b01,
    RUN_TO  = 2'b10,
    RUN_FOR = 2'b11
  } sched_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10
  } sched_state_e;

  typedef struct packed {
    sched_mode_e             mode;
    logic [SCHED_TIME_W-1:0] data;
  } sched_cmd_t;

endpackage

// File: rtl/anasymod_cmd_fifo.sv
// DEPTH-entry synchronous command queue with occupancy count and a flush
// that discards everything, including a push in the same cycle.
module anasymod_cmd_fifo
  import anasymod_sched_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          emu_clk,
  input  logic          emu_rst_n,
  input  logic          push,
  input  sched_cmd_t    push_cmd,
  input  logic          pop,
  input  logic          flush,
  output sched_cmd_t    head_cmd,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  sched_cmd_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push && !full && !flush;
  assign pop_ok   = pop && !empty && !flush;
  assign head_cmd = mem[rd_ptr];

  // NOTE: payload storage is deliberately not reset; the pointers and level
  // alone decide which entries are valid, so the array stays plain RAM.
  always_ff @(posedge emu_clk) begin
    if (push_ok) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_anasymod_sched.sv
// Emulator time-step controller: queued timing commands drive a per-cycle dt
// request and a decimation strobe. Define ANASYMOD_SCHED_FLUSH_EN for sched_flush.
module ctrl_anasymod_sched
  import anasymod_sched_pkg::*;
#(
  parameter  int TIME_WIDTH = SCHED_TIME_W,
  parameter  int DT_WIDTH   = 27,
  parameter  int DEC_WIDTH  = 24,
  parameter  int DEPTH      = 4,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic                  emu_clk,
  input  logic                  emu_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_mode,
  input  logic [TIME_WIDTH-1:0] cmd_data,
  input  logic [TIME_WIDTH-1:0] emu_time,
  input  logic [DEC_WIDTH-1:0]  emu_dec_thr,
`ifdef ANASYMOD_SCHED_FLUSH_EN
  input  logic                  sched_flush,
`endif
  output logic [DT_WIDTH-1:0]   emu_dt_req,
  output logic                  emu_dec_cmp,
  output logic [1:0]            sched_state,
  output logic [LW-1:0]         sched_level,
  output logic                  sched_done
);

  localparam logic [DT_WIDTH-1:0]   DT_MAX     = '1;
  localparam logic [TIME_WIDTH:0]   DT_MAX_EXT = {{(TIME_WIDTH + 1 - DT_WIDTH){1'b0}}, DT_MAX};

  sched_state_e          state;
  sched_mode_e           cur_mode;
  logic [TIME_WIDTH-1:0] target;
  logic [TIME_WIDTH-1:0] run_for_target;
  logic [TIME_WIDTH:0]   run_for_sum;
  logic [TIME_WIDTH:0]   time_diff;
  sched_cmd_t            push_cmd;
  sched_cmd_t            head_cmd;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  flush;
  logic                  cmd_done;
  logic                  dec_hit;
  logic [DEC_WIDTH-1:0]  dec_cnt;

`ifdef ANASYMOD_SCHED_FLUSH_EN
  assign flush = sched_flush;
`else
  assign flush = 1'b0;
`endif

  assign cmd_ready   = !fifo_full;
  assign push_cmd    = '{mode: sched_mode_e'(cmd_mode), data: cmd_data};
  assign sched_state = state;

  anasymod_cmd_fifo #(.DEPTH(DEPTH)) u_cmd_fifo (
    .emu_clk  (emu_clk),
    .emu_rst_n(emu_rst_n),
    .push     (cmd_valid),
    .push_cmd (push_cmd),
    .pop      (state == LOAD),
    .flush    (flush),
    .head_cmd (head_cmd),
    .level    (sched_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Relative targets are computed one bit wider so an overflow saturates.
  assign run_for_sum    = {1'b0, emu_time} + {1'b0, head_cmd.data};
  assign run_for_target = run_for_sum[TIME_WIDTH] ? '1 : run_for_sum[TIME_WIDTH-1:0];
  assign time_diff      = {1'b0, target} - {1'b0, emu_time};

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cmd_done = 1'b0;
    case (cur_mode)
      FREE, STALL: cmd_done = !fifo_empty;
      default:     cmd_done = (emu_time >= target);
    endcase
  end

  always_comb begin
    emu_dt_req = '0;
    if (state == RUN) begin
      case (cur_mode)
        FREE:    emu_dt_req = DT_MAX;
        STALL:   emu_dt_req = '0;
        default: if (target > emu_time)
                   emu_dt_req = (time_diff > DT_MAX_EXT) ? DT_MAX : time_diff[DT_WIDTH-1:0];
      endcase
    end
  end

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state      <= IDLE;
      cur_mode   <= FREE;
      target     <= '0;
      sched_done <= 1'b0;
    end else begin
      sched_done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (!fifo_empty) state <= LOAD;
          LOAD: begin
            cur_mode <= head_cmd.mode;
            target   <= (head_cmd.mode == RUN_FOR) ? run_for_target : head_cmd.data;
            state    <= RUN;
          end
          RUN: if (cmd_done) begin
            if (!fifo_empty) begin
              state <= LOAD;
            end else begin
              state      <= IDLE;
              sched_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Decimation only counts cycles on which time actually advances.
  assign dec_hit     = (emu_dt_req != '0) && (dec_cnt >= emu_dec_thr);
  assign emu_dec_cmp = dec_hit;

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      dec_cnt <= '0;
    end else if (emu_dt_req != '0) begin
      dec_cnt <= dec_hit ? '0 : dec_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_anasymod_sched.sv
// Directed bench for ctrl_anasymod_sched with DT_WIDTH=8; flush scenario is
// compiled in only when ANASYMOD_SCHED_FLUSH_EN is defined.
module tb_ctrl_anasymod_sched;

  localparam int TW = 40;
  localparam int DW = 8;
  localparam int CW = 24;
  localparam int LW = 3;

  logic          emu_clk     = 1'b0;
  logic          emu_rst_n   = 1'b0;
  logic          cmd_valid   = 1'b0;
  logic [1:0]    cmd_mode    = 2'b00;
  logic [TW-1:0] cmd_data    = '0;
  logic [TW-1:0] emu_time    = '0;
  logic [CW-1:0] emu_dec_thr = '1;
`ifdef ANASYMOD_SCHED_FLUSH_EN
  logic          sched_flush = 1'b0;
`endif
  logic          cmd_ready;
  logic [DW-1:0] emu_dt_req;
  logic          emu_dec_cmp;
  logic [1:0]    sched_state;
  logic [LW-1:0] sched_level;
  logic          sched_done;

  int n_checks = 0;
  int n_errors = 0;

  ctrl_anasymod_sched #(.TIME_WIDTH(TW), .DT_WIDTH(DW), .DEC_WIDTH(CW), .DEPTH(4)) dut (
    .emu_clk    (emu_clk),
    .emu_rst_n  (emu_rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_data   (cmd_data),
    .emu_time   (emu_time),
    .emu_dec_thr(emu_dec_thr),
`ifdef ANASYMOD_SCHED_FLUSH_EN
    .sched_flush(sched_flush),
`endif
    .emu_dt_req (emu_dt_req),
    .emu_dec_cmp(emu_dec_cmp),
    .sched_state(sched_state),
    .sched_level(sched_level),
    .sched_done (sched_done)
  );

  always #5 emu_clk = ~emu_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    cmd_valid   = 1'b0;
    emu_time    = '0;
    emu_dec_thr = '1;
`ifdef ANASYMOD_SCHED_FLUSH_EN
    sched_flush = 1'b0;
`endif
    emu_rst_n = 1'b0;
    @(negedge emu_clk);
    @(negedge emu_clk);
    emu_rst_n = 1'b1;
  endtask

  // Drives one command for a single cycle; returns at the following negedge.
  task automatic push(input logic [1:0] m, input logic [TW-1:0] d);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_data  = d;
    @(negedge emu_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (emu_dt_req !== 8'd0) begin n_errors++; $display("FAIL rst_dt: got %0d expected 0", emu_dt_req); end
    n_checks++; if (emu_dec_cmp !== 1'b0) begin n_errors++; $display("FAIL rst_cmp: got %0b expected 0", emu_dec_cmp); end
    n_checks++; if (sched_done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %0b expected 0", sched_done); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %0b expected 1", cmd_ready); end
    n_checks++; if (sched_level !== 3'd0) begin n_errors++; $display("FAIL rst_level: got %0d expected 0", sched_level); end
    n_checks++; if (sched_state !== 2'd0) begin n_errors++; $display("FAIL rst_state: got %0d expected 0", sched_state); end
  endtask

  task automatic test_run_to();
    int exp_dt [4] = '{255, 255, 255, 235};
    do_reset();
    push(2'b10, 40'd1000);
    n_checks++; if (sched_state !== 2'd0 || sched_level !== 3'd1) begin n_errors++; $display("FAIL runto_queued: got state %0d level %0d expected 0/1", sched_state, sched_level); end
    @(negedge emu_clk);
    n_checks++; if (sched_state !== 2'd1 || emu_dt_req !== 8'd0) begin n_errors++; $display("FAIL runto_load: got state %0d dt %0d expected 1/0", sched_state, emu_dt_req); end
    for (int i = 0; i < 4; i++) begin
      @(negedge emu_clk);
      n_checks++; if (emu_dt_req !== 8'(exp_dt[i])) begin n_errors++; $display("FAIL runto_dt[%0d]: got %0d expected %0d", i, emu_dt_req, exp_dt[i]); end
      n_checks++; if (sched_done !== 1'b0) begin n_errors++; $display("FAIL runto_early_done[%0d]: got %0b expected 0", i, sched_done); end
      emu_time = emu_time + TW'(emu_dt_req);
    end
    @(negedge emu_clk);
    n_checks++; if (sched_state !== 2'd0 || sched_done !== 1'b1 || emu_dt_req !== 8'd0) begin n_errors++; $display("FAIL runto_end: got state %0d done %0b dt %0d expected 0/1/0", sched_state, sched_done, emu_dt_req); end
    @(negedge emu_clk);
    n_checks++; if (sched_done !== 1'b0) begin n_errors++; $display("FAIL runto_done_pulse: got %0b expected 0", sched_done); end
  endtask

  task automatic test_run_for();
    do_reset();
    emu_time = 40'd200;
    push(2'b11, 40'd50);
    @(negedge emu_clk);
    @(negedge emu_clk);
    n_checks++; if (emu_dt_req !== 8'd50 || sched_state !== 2'd2) begin n_errors++; $display("FAIL runfor_dt: got dt %0d state %0d expected 50/2", emu_dt_req, sched_state); end
    emu_time = 40'd250;
    @(negedge emu_clk);
    n_checks++; if (sched_state !== 2'd0 || sched_done !== 1'b1) begin n_errors++; $display("FAIL runfor_end: got state %0d done %0b expected 0/1", sched_state, sched_done); end
  endtask

  task automatic test_free_stall();
    do_reset();
    push(2'b00, '0);
    @(negedge emu_clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge emu_clk);
      n_checks++; if (emu_dt_req !== 8'd255 || sched_done !== 1'b0) begin n_errors++; $display("FAIL free_dt[%0d]: got dt %0d done %0b expected 255/0", i, emu_dt_req, sched_done); end
    end
    push(2'b01, '0);
    n_checks++; if (emu_dt_req !== 8'd255 || sched_level !== 3'd1) begin n_errors++; $display("FAIL free_preempt: got dt %0d level %0d expected 255/1", emu_dt_req, sched_level); end
    @(negedge emu_clk);
    n_checks++; if (sched_state !== 2'd1 || emu_dt_req !== 8'd0) begin n_errors++; $display("FAIL stall_load: got state %0d dt %0d expected 1/0", sched_state, emu_dt_req); end
    for (int i = 0; i < 4; i++) begin
      @(negedge emu_clk);
      n_checks++; if (sched_state !== 2'd2 || emu_dt_req !== 8'd0 || sched_done !== 1'b0 || sched_level !== 3'd0) begin n_errors++; $display("FAIL stall_run[%0d]: got state %0d dt %0d done %0b level %0d expected 2/0/0/0", i, sched_state, emu_dt_req, sched_done, sched_level); end
    end
    // Back into FREE, then queue one more and pull reset asynchronously.
    push(2'b00, '0);
    @(negedge emu_clk);
    @(negedge emu_clk);
    n_checks++; if (emu_dt_req !== 8'd255) begin n_errors++; $display("FAIL free_again: got %0d expected 255", emu_dt_req); end
    cmd_valid = 1'b1;
    cmd_mode  = 2'b00;
    @(posedge emu_clk);
    #2;
    emu_rst_n = 1'b0;
    #1;
    n_checks++; if (emu_dt_req !== 8'd0 || sched_state !== 2'd0 || sched_level !== 3'd0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL async_rst: got dt %0d state %0d level %0d ready %0b expected 0/0/0/1", emu_dt_req, sched_state, sched_level, cmd_ready); end
    cmd_valid = 1'b0;
    @(negedge emu_clk);
    emu_rst_n = 1'b1;
  endtask

  task automatic test_queue_full();
    do_reset();
    push(2'b10, 40'd100);
    @(negedge emu_clk);
    @(negedge emu_clk);
    n_checks++; if (sched_state !== 2'd2) begin n_errors++; $display("FAIL full_run: got state %0d expected 2", sched_state); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL full_ready[%0d]: got %0b expected 1", i, cmd_ready); end
      push(2'b00, TW'(i));
    end
    n_checks++; if (sched_level !== 3'd4 || cmd_ready !== 1'b0) begin n_errors++; $display("FAIL full_level: got level %0d ready %0b expected 4/0", sched_level, cmd_ready); end
    cmd_valid = 1'b1;
    cmd_mode  = 2'b01;
    for (int i = 0; i < 2; i++) begin
      @(negedge emu_clk);
      n_checks++; if (sched_level !== 3'd4 || cmd_ready !== 1'b0) begin n_errors++; $display("FAIL full_hold[%0d]: got level %0d ready %0b expected 4/0", i, sched_level, cmd_ready); end
    end
    emu_time = 40'd100;
    @(negedge emu_clk);
    n_checks++; if (sched_state !== 2'd1 || sched_level !== 3'd4 || cmd_ready !== 1'b0) begin n_errors++; $display("FAIL full_load: got state %0d level %0d ready %0b expected 1/4/0", sched_state, sched_level, cmd_ready); end
    @(negedge emu_clk);
    n_checks++; if (sched_level !== 3'd3 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL full_pop: got level %0d ready %0b expected 3/1", sched_level, cmd_ready); end
    @(negedge emu_clk);
    cmd_valid = 1'b0;
    n_checks++; if (sched_level !== 3'd4) begin n_errors++; $display("FAIL full_fifth: got level %0d expected 4", sched_level); end
  endtask

  task automatic test_decimation();
    logic exp_adv;
    logic exp_cmp;
    do_reset();
    emu_dec_thr = 24'd3;
    for (int c = 0; c <= 25; c++) begin
      exp_adv = (c >= 3 && c <= 9) || (c >= 17);
      exp_cmp = (c == 6) || (c == 17) || (c == 21) || (c >= 23);
      n_checks++; if ((emu_dt_req != 8'd0) !== exp_adv) begin n_errors++; $display("FAIL dec_adv[%0d]: got dt %0d expected advancing=%0b", c, emu_dt_req, exp_adv); end
      n_checks++; if (emu_dec_cmp !== exp_cmp) begin n_errors++; $display("FAIL dec_cmp[%0d]: got %0b expected %0b", c, emu_dec_cmp, exp_cmp); end
      cmd_valid = (c == 0) || (c == 8) || (c == 14);
      cmd_mode  = (c == 8) ? 2'b01 : 2'b00;
      if (c == 22) emu_dec_thr = '0;
      @(negedge emu_clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_run_to_past();
    do_reset();
    emu_time = 40'h100;
    push(2'b10, 40'hFF);
    @(negedge emu_clk);
    @(negedge emu_clk);
    n_checks++; if (sched_state !== 2'd2 || emu_dt_req !== 8'd0) begin n_errors++; $display("FAIL past_run: got state %0d dt %0d expected 2/0", sched_state, emu_dt_req); end
    @(negedge emu_clk);
    n_checks++; if (sched_state !== 2'd0 || sched_done !== 1'b1) begin n_errors++; $display("FAIL past_done: got state %0d done %0b expected 0/1", sched_state, sched_done); end
  endtask

`ifdef ANASYMOD_SCHED_FLUSH_EN
  task automatic test_flush();
    do_reset();
    push(2'b10, 40'd1000);
    push(2'b00, '0);
    @(negedge emu_clk);
    n_checks++; if (sched_state !== 2'd2 || sched_level !== 3'd1 || emu_dt_req !== 8'd255) begin n_errors++; $display("FAIL flush_pre: got state %0d level %0d dt %0d expected 2/1/255", sched_state, sched_level, emu_dt_req); end
    sched_flush = 1'b1;
    cmd_valid   = 1'b1;
    cmd_mode    = 2'b01;
    @(negedge emu_clk);
    sched_flush = 1'b0;
    cmd_valid   = 1'b0;
    n_checks++; if (sched_state !== 2'd0 || sched_level !== 3'd0 || emu_dt_req !== 8'd0 || sched_done !== 1'b0) begin n_errors++; $display("FAIL flush_post: got state %0d level %0d dt %0d done %0b expected 0/0/0/0", sched_state, sched_level, emu_dt_req, sched_done); end
    @(negedge emu_clk);
    n_checks++; if (sched_state !== 2'd0 || sched_level !== 3'd0 || sched_done !== 1'b0) begin n_errors++; $display("FAIL flush_idle: got state %0d level %0d done %0b expected 0/0/0", sched_state, sched_level, sched_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_run_to();
    test_run_for();
    test_free_stall();
    test_queue_full();
    test_decimation();
    test_run_to_past();
`ifdef ANASYMOD_SCHED_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
